// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with a 1-entry holding register
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          DIV_W       = 16,
  parameter int          DEFAULT_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx,
  output logic        tx_ready
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state, state_n;
  logic               tx_q, tx_n;
  logic [7:0]         hold, shift;
  logic               hold_full, overrun;
  logic [DIV_W-1:0]   div_reg, cur_div, baudcnt, eff_div;
  logic [2:0]         bitcnt;
  logic               shift_adv;
  logic               hit, wr_txdata, wr_status, wr_baud;
  logic               baud_done, load, busy;
`ifdef UART_TX_PARITY_EN
  logic               par;
`endif
  logic               unused_bits;

  assign unused_bits = ^{a[1:0], wd};

  assign hit       = (a[31:4] == BASE_ADDR[31:4]);
  assign wr_txdata = we && hit && (a[3:2] == 2'd0);
  assign wr_status = we && hit && (a[3:2] == 2'd1);
  assign wr_baud   = we && hit && (a[3:2] == 2'd2);

  assign eff_div   = (div_reg == '0) ? DIV_W'(1) : div_reg;
  assign baud_done = (baudcnt == '0);
  assign busy      = (state != IDLE);

  // A frame starts from IDLE, or directly out of the last stop-bit cycle when a byte is waiting.
  assign load = hold_full && ((state == IDLE) || ((state == STOP) && baud_done));

  always_comb begin
    rd = 32'd0;
    if (hit) begin
      case (a[3:2])
        2'd1:    rd = {29'd0, overrun, hold_full, busy};
        2'd2:    rd = 32'(div_reg);
        default: rd = 32'd0;
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ~hold_full;

  // tx_n is the line level for the state being entered, so tx changes exactly on the transition edge.
  always_comb begin
    state_n   = state;
    tx_n      = tx_q;
    shift_adv = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (hold_full) begin
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          state_n = DATA;
          tx_n    = shift[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          if (bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            tx_n      = shift[1];
            shift_adv = 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          if (hold_full) begin
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      tx_q  <= 1'b1;
    end else begin
      state <= state_n;
      tx_q  <= tx_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift   <= '0;
      bitcnt  <= '0;
      baudcnt <= '0;
      cur_div <= DIV_W'(DEFAULT_DIV);
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (load) begin
      shift   <= hold;
      bitcnt  <= '0;
      baudcnt <= eff_div - DIV_W'(1);
      cur_div <= eff_div;
`ifdef UART_TX_PARITY_EN
      par     <= ^hold;
`endif
    end else if (state != IDLE) begin
      if (baud_done) begin
        baudcnt <= cur_div - DIV_W'(1);
        if (shift_adv) begin
          shift  <= {1'b0, shift[7:1]};
          bitcnt <= bitcnt + 3'd1;
        end
      end else begin
        baudcnt <= baudcnt - DIV_W'(1);
      end
    end
  end

  // A store arriving while the holding register drains is accepted, not counted as overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
      div_reg   <= DIV_W'(DEFAULT_DIV);
    end else begin
      if (wr_txdata && (!hold_full || load)) begin
        hold      <= wd[7:0];
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (wr_txdata && hold_full && !load)
        overrun <= 1'b1;
      else if (wr_status && wd[2])
        overrun <= 1'b0;

      if (wr_baud)
        div_reg <= wd[DIV_W-1:0];
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - randomized self-checking bench for mmio_uart_tx against a line-level model
module tb_mmio_uart_tx;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic        tx, tx_ready;

  always #5 clk = ~clk;

  mmio_uart_tx #(.BASE_ADDR(32'h0000_1000), .DIV_W(16), .DEFAULT_DIV(16)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd),
    .rd(rd), .tx(tx), .tx_ready(tx_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: future per-cycle line levels plus the visible register contents.
  bit         m_line[$];
  bit         m_hold_full;
  bit         m_overrun;
  logic [7:0] m_hold;
  logic [15:0] m_div;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] addr);
    if (addr[31:4] != 28'h0000100) return 32'd0;
    case (addr[3:2])
      2'd1:    return {29'd0, m_overrun, m_hold_full, m_line.size() != 0};
      2'd2:    return {16'd0, m_div};
      default: return 32'd0;
    endcase
  endfunction

  task automatic push_frame(input logic [7:0] data, input int d);
    bit fb[$];
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(data[i]);
`ifdef UART_TX_PARITY_EN
    fb.push_back(^data);
`endif
    fb.push_back(1'b1);
    foreach (fb[i]) repeat (d) m_line.push_back(fb[i]);
  endtask

  task automatic model_edge();
    bit drain, hit, set_ovr, new_hf;
    if (!reset) begin
      m_line.delete();
      m_hold_full = 0;
      m_overrun   = 0;
      m_hold      = 8'd0;
      m_div       = 16'd16;
      return;
    end
    if (m_line.size() != 0) void'(m_line.pop_front());
    drain   = m_hold_full && (m_line.size() == 0);
    hit     = (a[31:4] == 28'h0000100);
    set_ovr = 0;
    new_hf  = m_hold_full && !drain;
    if (drain) push_frame(m_hold, (m_div == 16'd0) ? 1 : int'(m_div));
    if (we && hit) begin
      case (a[3:2])
        2'd0: if (!m_hold_full || drain) begin
                m_hold = wd[7:0];
                new_hf = 1;
              end else begin
                set_ovr = 1;
              end
        2'd1: if (wd[2]) m_overrun = 0;
        2'd2: m_div = wd[15:0];
        default: ;
      endcase
    end
    if (set_ovr) m_overrun = 1;
    m_hold_full = new_hf;
  endtask

  task automatic cyc(input bit rst_n, input bit w, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    reset = rst_n;
    we    = w;
    a     = addr;
    wd    = data;
    #1;
    check("tx", {31'd0, tx}, (m_line.size() != 0) ? {31'd0, m_line[0]} : 32'd1);
    check("tx_ready", {31'd0, tx_ready}, {31'd0, !m_hold_full});
    check("rd", rd, exp_rd(addr));
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int n, input logic [31:0] addr);
    repeat (n) cyc(1'b1, 1'b0, addr, 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    cyc(1'b1, 1'b1, addr, data);
  endtask

  int          k;
  logic [31:0] ad, dv;

  initial begin
    repeat (2) @(posedge clk);
    model_edge();
    cyc(1'b0, 1'b0, 32'h0000_1008, 32'd0);
    idle(2, 32'h0000_1004);

    wr(32'h0000_1000, 32'h55);
    idle(170, 32'h0000_1004);

    wr(32'h0000_1008, 32'd4);
    wr(32'h0000_1000, 32'hA5);
    wr(32'h0000_1000, 32'h3C);
    idle(90, 32'h0000_1004);

    wr(32'h0000_1000, 32'h01);
    wr(32'h0000_1000, 32'h02);
    wr(32'h0000_1000, 32'h03);
    idle(5, 32'h0000_1004);
    wr(32'h0000_1004, 32'h4);
    idle(100, 32'h0000_1004);

    wr(32'h0000_1008, 32'd0);
    wr(32'h0000_100C, 32'hFFFF_FFFF);
    idle(1, 32'h0000_100C);
    wr(32'h0000_2000, 32'h77);
    wr(32'h0000_2008, 32'd9);
    idle(1, 32'h0000_1008);
    wr(32'h0000_1000, 32'h5A);
    idle(15, 32'h0000_1004);

    wr(32'h0000_1008, 32'd16);
    wr(32'h0000_1000, 32'hFF);
    wr(32'h0000_1000, 32'h11);
    idle(40, 32'h0000_1004);
    cyc(1'b0, 1'b0, 32'h0000_1004, 32'd0);
    idle(3, 32'h0000_1008);
    idle(20, 32'h0000_1004);

    for (int i = 0; i < 4000; i++) begin
      k  = int'($urandom_range(0, 99));
      ad = 32'h0000_1000 | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) ad = $urandom;
      dv = $urandom;
      if (k == 0)
        cyc(1'b0, 1'b0, ad, dv);
      else if (k < 3)
        wr(ad, dv);
      else if (k < 10)
        wr(32'h0000_1000 | 32'($urandom_range(0, 3)), dv);
      else if (k < 12)
        wr(32'h0000_1004, dv);
      else if (k < 14) begin
        dv[15:0] = 16'($urandom_range(0, 5));
        wr(32'h0000_1008, dv);
      end else
        idle(1, ad);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
